// File: rtl/mos6502_pkg.sv
// Shared constants and types for the 6502 subset core.
package mos6502_pkg;

  // Opcodes handled by the core; anything else behaves as a 1-byte NOP.
  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_LDX_IMM = 8'hA2;
  localparam logic [7:0] OP_LDY_IMM = 8'hA0;
  localparam logic [7:0] OP_LDA_ABS = 8'hAD;
  localparam logic [7:0] OP_LDX_ABS = 8'hAE;
  localparam logic [7:0] OP_LDY_ABS = 8'hAC;
  localparam logic [7:0] OP_STA_ABS = 8'h8D;
  localparam logic [7:0] OP_STX_ABS = 8'h8E;
  localparam logic [7:0] OP_STY_ABS = 8'h8C;
  localparam logic [7:0] OP_JMP_ABS = 8'h4C;
  localparam logic [7:0] OP_NOP     = 8'hEA;

  // Vector addresses (low byte; high byte at +1).
  localparam logic [15:0] VEC_NMI   = 16'hFFFA;
  localparam logic [15:0] VEC_RESET = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

  // Status register bit positions.
  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

  typedef enum logic [2:0] {S_RST0, S_RST1, S_FETCH, S_T1, S_T2, S_T3} state_t;
  typedef enum logic [1:0] {AM_IMP, AM_IMM, AM_ABS} amode_t;
  typedef enum logic [1:0] {R_A, R_X, R_Y} rsel_t;

  typedef struct packed {
    amode_t mode;
    rsel_t  rsel;
    logic   is_store;
    logic   is_jump;
  } decode_t;

  // Replace N and Z in p according to a loaded value.
  function automatic logic [7:0] nz_update(input logic [7:0] p, input logic [7:0] v);
    logic [7:0] r;
    r      = p;
    r[P_N] = v[7];
    r[P_Z] = (v == 8'h00);
    return r;
  endfunction

endpackage

// File: rtl/mos6502_decode.sv
// Opcode to {addressing mode, register, store, jump} mapping.
module mos6502_decode
  import mos6502_pkg::*;
(
  input  logic [7:0] opcode,
  output decode_t    dec
);

  // Unlisted opcodes fall through to the implied (NOP) default.
  always_comb begin
    dec = '{mode: AM_IMP, rsel: R_A, is_store: 1'b0, is_jump: 1'b0};
    case (opcode)
      OP_LDA_IMM: dec = '{mode: AM_IMM, rsel: R_A, is_store: 1'b0, is_jump: 1'b0};
      OP_LDX_IMM: dec = '{mode: AM_IMM, rsel: R_X, is_store: 1'b0, is_jump: 1'b0};
      OP_LDY_IMM: dec = '{mode: AM_IMM, rsel: R_Y, is_store: 1'b0, is_jump: 1'b0};
      OP_LDA_ABS: dec = '{mode: AM_ABS, rsel: R_A, is_store: 1'b0, is_jump: 1'b0};
      OP_LDX_ABS: dec = '{mode: AM_ABS, rsel: R_X, is_store: 1'b0, is_jump: 1'b0};
      OP_LDY_ABS: dec = '{mode: AM_ABS, rsel: R_Y, is_store: 1'b0, is_jump: 1'b0};
      OP_STA_ABS: dec = '{mode: AM_ABS, rsel: R_A, is_store: 1'b1, is_jump: 1'b0};
      OP_STX_ABS: dec = '{mode: AM_ABS, rsel: R_X, is_store: 1'b1, is_jump: 1'b0};
      OP_STY_ABS: dec = '{mode: AM_ABS, rsel: R_Y, is_store: 1'b1, is_jump: 1'b0};
      OP_JMP_ABS: dec = '{mode: AM_ABS, rsel: R_A, is_store: 1'b0, is_jump: 1'b1};
      default: ;
    endcase
  end

endmodule

// File: rtl/mos6502_proc.sv
// Cycle-accurate 6502 subset: reset vector, LD*/ST* imm/abs, JMP abs, NOP.
module mos6502_proc
  import mos6502_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rd_data,
  output logic [15:0] address,
  output logic [7:0]  wr_data,
  output logic        wr_enable
);

  state_t      state, state_nxt;
  logic [15:0] PC;
  logic [7:0]  P, A, X, Y, SP;
  logic [7:0]  ir, lo, hi;
  decode_t     dec;
  logic [7:0]  sel_reg;

  mos6502_decode u_decode (.opcode(ir), .dec(dec));

  // Register selected by the current instruction (store source).
  always_comb begin
    sel_reg = A;
    case (dec.rsel)
      R_X:     sel_reg = X;
      R_Y:     sel_reg = Y;
      default: sel_reg = A;
    endcase
  end

  // State register; reset restarts the vector sequence from any state.
  always_ff @(posedge clk) begin
    if (reset) state <= S_RST0;
    else       state <= state_nxt;
  end

  // Next-state sequencing per instruction class.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RST0:  state_nxt = S_RST1;
      S_RST1:  state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_T1;
      S_T1:    state_nxt = (dec.mode == AM_ABS) ? S_T2 : S_FETCH;
      S_T2:    state_nxt = dec.is_jump ? S_FETCH : S_T3;
      S_T3:    state_nxt = S_FETCH;
      default: state_nxt = S_RST0;
    endcase
  end

  // Bus outputs; the write strobe is masked while reset is asserted.
  always_comb begin
    address   = PC;
    wr_enable = 1'b0;
    wr_data   = 8'h00;
    case (state)
      S_RST0:  address = RESET_VECTOR;
      S_RST1:  address = RESET_VECTOR + 16'd1;
      S_T3: begin
        address = {hi, lo};
        if (dec.is_store && !reset) begin
          wr_enable = 1'b1;
          wr_data   = sel_reg;
        end
      end
      default: ;
    endcase
  end

  // Architectural registers and operand latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      PC <= 16'h0000;
      P  <= 8'h24;
      A  <= 8'h00;
      X  <= 8'h00;
      Y  <= 8'h00;
      SP <= 8'hFD;
      ir <= 8'h00;
      lo <= 8'h00;
      hi <= 8'h00;
    end else begin
      case (state)
        S_RST0:  lo <= rd_data;
        S_RST1:  PC <= {rd_data, lo};
        S_FETCH: begin
          ir <= rd_data;
          PC <= PC + 16'd1;
        end
        S_T1: begin
          // Implied mode does a dummy read and leaves PC alone.
          if (dec.mode != AM_IMP) PC <= PC + 16'd1;
          if (dec.mode == AM_ABS) lo <= rd_data;
          if (dec.mode == AM_IMM) begin
            case (dec.rsel)
              R_X:     X <= rd_data;
              R_Y:     Y <= rd_data;
              default: A <= rd_data;
            endcase
            P <= nz_update(P, rd_data);
          end
        end
        S_T2: begin
          if (dec.is_jump) begin
            PC <= {rd_data, lo};
          end else begin
            hi <= rd_data;
            PC <= PC + 16'd1;
          end
        end
        S_T3: begin
          if (!dec.is_store) begin
            case (dec.rsel)
              R_X:     X <= rd_data;
              R_Y:     Y <= rd_data;
              default: A <= rd_data;
            endcase
            P <= nz_update(P, rd_data);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mos6502_proc.sv
// Scoreboard bench: directed program, expected fetches/writes queued, monitor compares.
module tb_mos6502_proc;
  import mos6502_pkg::*;

  logic        clk;
  logic        reset;
  logic [7:0]  rd_data;
  logic [15:0] address;
  logic [7:0]  wr_data;
  logic        wr_enable;

  mos6502_proc #(.RESET_VECTOR(16'hFFFC)) dut (
    .clk(clk), .reset(reset), .rd_data(rd_data),
    .address(address), .wr_data(wr_data), .wr_enable(wr_enable)
  );

  logic [7:0] mem [0:65535];
  assign rd_data = mem[address];

  typedef struct {
    logic [15:0] pc;
    int          gap;
    logic [31:0] regs;   // {A, X, Y, P} at the start of the fetch
  } fetch_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  fetch_t fetch_q[$];
  wr_t    wr_q[$];

  int   cyc = 0;
  logic rst_q = 1'b0;
  logic done = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  int   last_rst_cyc = 0;
  int   prev_fetch_cyc = 0;
  logic after_rst = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compares every observed fetch and write against the queues.
  always @(negedge clk) begin
    if (done) begin
      chk("fetch_queue_drained", 64'(fetch_q.size()), 64'd0);
      chk("write_queue_drained", 64'(wr_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
    end else begin
      if (reset) begin
        last_rst_cyc = cyc;
        after_rst    = 1'b1;
      end
      if (rst_q) begin
        chk("reset_address", 64'(address), 64'hFFFC);
        chk("reset_wr", {55'd0, wr_enable, wr_data}, 64'd0);
        chk("reset_regs", {dut.PC, dut.P, dut.A, dut.X, dut.Y, dut.SP}, {16'h0000, 8'h24, 8'h00, 8'h00, 8'h00, 8'hFD});
      end
      if (wr_enable) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write", {address, wr_data}, 24'h0);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("write_addr", 64'(address), 64'(w.addr));
          chk("write_data", 64'(wr_data), 64'(w.data));
        end
      end
      if (!reset && !rst_q && dut.state == S_FETCH) begin
        if (fetch_q.size() == 0) begin
          chk("unexpected_fetch", 64'(dut.PC), 64'hFFFF_FFFF);
        end else begin
          fetch_t f;
          int     gap;
          f   = fetch_q.pop_front();
          gap = after_rst ? (cyc - last_rst_cyc) : (cyc - prev_fetch_cyc);
          chk("fetch_pc", 64'(dut.PC), 64'(f.pc));
          chk("fetch_address", 64'(address), 64'(f.pc));
          chk("fetch_gap", 64'(gap), 64'(f.gap));
          chk("fetch_regs", 64'({dut.A, dut.X, dut.Y, dut.P}), 64'(f.regs));
        end
        prev_fetch_cyc = cyc;
        after_rst      = 1'b0;
      end
    end
  end

  task automatic put(input logic [15:0] a, input logic [7:0] d);
    mem[a] = d;
  endtask

  task automatic exp_fetch(input logic [15:0] pc, input int gap, input logic [31:0] regs);
    fetch_t f;
    f.pc = pc; f.gap = gap; f.regs = regs;
    fetch_q.push_back(f);
  endtask

  task automatic exp_write(input logic [15:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    wr_q.push_back(w);
  endtask

  // Stimulus: program image, expectations, reset pulses.
  initial begin
    logic found;
    reset = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    put(16'hFFFC, 8'h00); put(16'hFFFD, 8'h80);
    put(16'h9000, 8'h80);
    put(16'h8000, 8'hAD); put(16'h8001, 8'h00); put(16'h8002, 8'h90); // LDA $9000
    put(16'h8003, 8'hA9); put(16'h8004, 8'h00);                       // LDA #00
    put(16'h8005, 8'hA9); put(16'h8006, 8'h5A);                       // LDA #5A
    put(16'h8007, 8'h8D); put(16'h8008, 8'h34); put(16'h8009, 8'h12); // STA $1234
    put(16'h800A, 8'h4C); put(16'h800B, 8'h00); put(16'h800C, 8'hC0); // JMP $C000
    put(16'hC000, 8'h02);                                             // unknown
    put(16'hC001, 8'hA2); put(16'hC002, 8'hFF);                       // LDX #FF
    put(16'hC003, 8'hA0); put(16'hC004, 8'h01);                       // LDY #01
    put(16'hC005, 8'h8E); put(16'hC006, 8'h00); put(16'hC007, 8'h20); // STX $2000
    put(16'hC008, 8'h8C); put(16'hC009, 8'h01); put(16'hC00A, 8'h20); // STY $2001
    put(16'hC00B, 8'hAE); put(16'hC00C, 8'h00); put(16'hC00D, 8'h90); // LDX $9000
    put(16'hC00E, 8'hEA);                                             // NOP
    put(16'hC00F, 8'h8D); put(16'hC010, 8'h00); put(16'hC011, 8'h30); // STA $3000 (aborted)

    exp_fetch(16'h8000, 3, 32'h00_00_00_24);
    exp_fetch(16'h8003, 4, 32'h80_00_00_A4);
    exp_fetch(16'h8005, 2, 32'h00_00_00_26);
    exp_fetch(16'h8007, 2, 32'h5A_00_00_24);
    exp_fetch(16'h800A, 4, 32'h5A_00_00_24);
    exp_fetch(16'hC000, 3, 32'h5A_00_00_24);
    exp_fetch(16'hC001, 2, 32'h5A_00_00_24);
    exp_fetch(16'hC003, 2, 32'h5A_FF_00_A4);
    exp_fetch(16'hC005, 2, 32'h5A_FF_01_24);
    exp_fetch(16'hC008, 4, 32'h5A_FF_01_24);
    exp_fetch(16'hC00B, 4, 32'h5A_FF_01_24);
    exp_fetch(16'hC00E, 4, 32'h5A_80_01_A4);
    exp_fetch(16'hC00F, 2, 32'h5A_80_01_A4);
    exp_write(16'h1234, 8'h5A);
    exp_write(16'h2000, 8'hFF);
    exp_write(16'h2001, 8'h01);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (dut.state == S_FETCH && dut.PC == 16'hC00F) found = 1'b1;
    end

    if (found) begin
      @(posedge clk);   // enter T1
      @(posedge clk);   // enter T2
      #1 reset = 1'b1;  // sampled at the end of T2: the store must not happen
      exp_fetch(16'h8000, 3, 32'h00_00_00_24);
      exp_fetch(16'h8003, 4, 32'h80_00_00_A4);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
    end

    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (fetch_q.size() == 0) break;
    end
    done = 1'b1;
  end

endmodule
